// File: rtl/bp_fe_bht_access_scheduler_pkg.sv
// Shared types and helpers for the BHT access scheduler: FSM states,
// queued update entries, the counter init value and the 2-bit saturating update.
package bp_fe_bht_access_scheduler_pkg;

    // Widest index a queued entry can carry; narrower tables zero-extend.
    localparam int bht_idx_max_width_gp = 16;

    // Weakly-not-taken value written to every counter after reset.
    localparam logic [1:0] bht_counter_init_gp = 2'b01;

    typedef enum logic [1:0] {
        INIT   = 2'b00,
        READY  = 2'b01,
        UPD_RD = 2'b10,
        UPD_WR = 2'b11
    } bht_sched_state_e;

    typedef struct packed {
        logic [bht_idx_max_width_gp-1:0] idx;
        logic                            taken;
    } bht_upd_entry_s;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] bht_sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : (ctr + 2'b01);
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : (ctr - 2'b01);
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_fe_bht_access_scheduler_fifo.sv
// Small register-based FIFO holding pending BHT update entries in arrival order.
// Enqueue is ignored when full; dequeue is ignored when empty.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 17,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic               full_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] ptr_last_lp = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_full_lp = cnt_width_lp'(els_p);

    logic [width_p-1:0]      mem_r [els_p];
    logic [ptr_width_lp-1:0] rptr_r;
    logic [ptr_width_lp-1:0] wptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    enq_s;
    logic                    deq_s;

    assign full_o = (count_r == cnt_full_lp);
    assign v_o    = (count_r != {cnt_width_lp{1'b0}});
    assign enq_s  = v_i & ~full_o;
    assign deq_s  = yumi_i & v_o;
    assign data_o = mem_r[rptr_r];

    // Storage write on enqueue.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_r[i] <= {width_p{1'b0}};
            end
        end else if (enq_s) begin
            mem_r[wptr_r] <= data_i;
        end else begin
            mem_r[wptr_r] <= mem_r[wptr_r];
        end
    end

    // Read/write pointers (wrap at els_p) and occupancy count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_r  <= {ptr_width_lp{1'b0}};
            wptr_r  <= {ptr_width_lp{1'b0}};
            count_r <= {cnt_width_lp{1'b0}};
        end else begin
            if (enq_s) begin
                wptr_r <= (wptr_r == ptr_last_lp) ? {ptr_width_lp{1'b0}} : (wptr_r + ptr_width_lp'(1));
            end
            if (deq_s) begin
                rptr_r <= (rptr_r == ptr_last_lp) ? {ptr_width_lp{1'b0}} : (rptr_r + ptr_width_lp'(1));
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bp_fe_bht_access_scheduler.sv
// Owner of the single-ported BHT SRAM. Sweeps the table to weakly-not-taken
// after reset, then arbitrates each cycle between prediction reads and queued
// counter updates, executing each update as a read followed by a write.
module bp_fe_bht_access_scheduler
    import bp_fe_bht_access_scheduler_pkg::*;
#(
    parameter int bht_idx_width_p = 9,
    parameter int upd_fifo_els_p  = 4,
    parameter int starve_limit_p  = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       read_v_i,
    input  logic [bht_idx_width_p-1:0] read_idx_i,
    output logic                       read_ready_o,
    output logic                       predict_v_o,
    output logic                       predict_o,
    input  logic                       upd_v_i,
    input  logic [bht_idx_width_p-1:0] upd_idx_i,
    input  logic                       upd_taken_i,
    output logic                       upd_ready_o,
    output logic                       mem_v_o,
    output logic                       mem_w_o,
    output logic [bht_idx_width_p-1:0] mem_addr_o,
    output logic [1:0]                 mem_data_o,
    input  logic [1:0]                 mem_data_i,
    output logic                       init_done_o
);

    localparam int starve_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [bht_idx_width_p-1:0] init_last_lp  = {bht_idx_width_p{1'b1}};
    localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);
    localparam int entry_width_lp = $bits(bht_upd_entry_s);

    bht_sched_state_e             state_r;
    bht_sched_state_e             state_next_s;
    logic [bht_idx_width_p-1:0]   init_ptr_r;
    logic [starve_width_lp-1:0]   starve_r;
    logic                         init_done_r;
    logic                         predict_v_r;

    bht_upd_entry_s               enq_entry_s;
    bht_upd_entry_s               head_entry_s;
    logic [bht_idx_width_p-1:0]   head_idx_s;
    logic                         unused_head_bits_s;
    logic                         fifo_v_s;
    logic                         fifo_full_s;
    logic                         enq_v_s;
    logic                         deq_s;

    logic                         force_upd_s;
    logic                         read_acc_s;
    logic                         upd_issue_s;
    logic                         read_ready_s;
    logic                         mem_v_s;
    logic                         mem_w_s;
    logic [bht_idx_width_p-1:0]   mem_addr_s;
    logic [1:0]                   mem_data_s;

    assign enq_entry_s        = '{idx: bht_idx_max_width_gp'(upd_idx_i), taken: upd_taken_i};
    assign head_idx_s         = head_entry_s.idx[bht_idx_width_p-1:0];
    assign unused_head_bits_s = ^head_entry_s.idx;

    assign upd_ready_o = init_done_r & ~fifo_full_s;
    assign enq_v_s     = upd_v_i & upd_ready_o;

    bsg_fifo_1r1w_small #(
        .width_p (entry_width_lp),
        .els_p   (upd_fifo_els_p)
    ) upd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (enq_v_s),
        .data_i    (enq_entry_s),
        .v_o       (fifo_v_s),
        .full_o    (fifo_full_s),
        .data_o    (head_entry_s),
        .yumi_i    (deq_s)
    );

    // An update must win when the queue is full or reads have starved it long enough.
    assign force_upd_s = (fifo_full_s | (starve_r == starve_max_lp)) & fifo_v_s;

    // Next-state, arbitration and SRAM command generation.
    always_comb begin
        state_next_s = state_r;
        read_ready_s = 1'b0;
        read_acc_s   = 1'b0;
        upd_issue_s  = 1'b0;
        deq_s        = 1'b0;
        mem_v_s      = 1'b0;
        mem_w_s      = 1'b0;
        mem_addr_s   = {bht_idx_width_p{1'b0}};
        mem_data_s   = 2'b00;
        case (state_r)
            INIT: begin
                mem_v_s    = 1'b1;
                mem_w_s    = 1'b1;
                mem_addr_s = init_ptr_r;
                mem_data_s = bht_counter_init_gp;
                if (init_ptr_r == init_last_lp) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = INIT;
                end
            end
            READY: begin
                read_ready_s = ~force_upd_s;
                if (force_upd_s) begin
                    upd_issue_s  = 1'b1;
                    mem_v_s      = 1'b1;
                    mem_addr_s   = head_idx_s;
                    state_next_s = UPD_WR;
                end else if (read_v_i) begin
                    read_acc_s   = 1'b1;
                    mem_v_s      = 1'b1;
                    mem_addr_s   = read_idx_i;
                    state_next_s = READY;
                end else if (fifo_v_s) begin
                    upd_issue_s  = 1'b1;
                    mem_v_s      = 1'b1;
                    mem_addr_s   = head_idx_s;
                    state_next_s = UPD_WR;
                end else begin
                    state_next_s = READY;
                end
            end
            UPD_RD: begin
                // Not entered in normal flow; behaves as an update read issue.
                if (fifo_v_s) begin
                    upd_issue_s  = 1'b1;
                    mem_v_s      = 1'b1;
                    mem_addr_s   = head_idx_s;
                    state_next_s = UPD_WR;
                end else begin
                    state_next_s = READY;
                end
            end
            UPD_WR: begin
                mem_v_s      = 1'b1;
                mem_w_s      = 1'b1;
                mem_addr_s   = head_idx_s;
                mem_data_s   = bht_sat_update(mem_data_i, head_entry_s.taken);
                deq_s        = 1'b1;
                state_next_s = READY;
            end
            default: begin
                state_next_s = INIT;
            end
        endcase
    end

    // FSM state, init sweep pointer and init-done flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= INIT;
            init_ptr_r  <= {bht_idx_width_p{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            init_done_r <= (state_next_s != INIT);
            if (state_r == INIT) begin
                init_ptr_r <= init_ptr_r + bht_idx_width_p'(1);
            end else begin
                init_ptr_r <= init_ptr_r;
            end
        end
    end

    // Starve counter: counts read wins over a non-empty queue, cleared by any update read.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_r <= {starve_width_lp{1'b0}};
        end else if (upd_issue_s) begin
            starve_r <= {starve_width_lp{1'b0}};
        end else if (read_acc_s && fifo_v_s && (starve_r != starve_max_lp)) begin
            starve_r <= starve_r + starve_width_lp'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Prediction is valid the cycle after an accepted read, when SRAM data returns.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            predict_v_r <= 1'b0;
        end else begin
            predict_v_r <= read_acc_s;
        end
    end

    // SRAM enables are held low while reset is asserted, regardless of state.
    assign mem_v_o      = mem_v_s & reset_n_i;
    assign mem_w_o      = mem_w_s & reset_n_i;
    assign mem_addr_o   = mem_addr_s;
    assign mem_data_o   = mem_data_s;
    assign read_ready_o = read_ready_s;
    assign predict_v_o  = predict_v_r;
    assign predict_o    = predict_v_r & mem_data_i[1];
    assign init_done_o  = init_done_r;

endmodule

// File: tb/tb_bp_fe_bht_access_scheduler.sv
// Directed bench for the BHT access scheduler with a behavioural SRAM,
// a reference counter table and scoreboard queues for predictions and updates.
module tb_bp_fe_bht_access_scheduler;

    localparam int IW = 4;
    localparam int N  = 16;

    typedef struct {
        logic [IW-1:0] idx;
        logic          taken;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          read_v;
    logic [IW-1:0] read_idx;
    logic          read_ready_o;
    logic          predict_v_o;
    logic          predict_o;
    logic          upd_v;
    logic [IW-1:0] upd_idx;
    logic          upd_taken;
    logic          upd_ready_o;
    logic          mem_v_o;
    logic          mem_w_o;
    logic [IW-1:0] mem_addr_o;
    logic [1:0]    mem_data_o;
    logic [1:0]    mem_data_i;
    logic          init_done_o;

    logic [1:0]    sram [N] = '{default: 2'b10};
    logic [1:0]    rd_q = 2'b00;

    logic [1:0]    ref_ctr [N];
    ent_t          upd_q [$];
    logic          pred_q [$];
    logic          pred_due;
    logic          pending_wr;

    logic          last_rr, last_mem_v, last_mem_w, last_upd_ready, last_enq, last_pred;
    logic [IW-1:0] last_addr;

    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    bp_fe_bht_access_scheduler #(
        .bht_idx_width_p (IW),
        .upd_fifo_els_p  (4),
        .starve_limit_p  (8)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .read_v_i     (read_v),
        .read_idx_i   (read_idx),
        .read_ready_o (read_ready_o),
        .predict_v_o  (predict_v_o),
        .predict_o    (predict_o),
        .upd_v_i      (upd_v),
        .upd_idx_i    (upd_idx),
        .upd_taken_i  (upd_taken),
        .upd_ready_o  (upd_ready_o),
        .mem_v_o      (mem_v_o),
        .mem_w_o      (mem_w_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .init_done_o  (init_done_o)
    );

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         rd_q <= sram[mem_addr_o];
        end
    end
    assign mem_data_i = rd_q;

    function automatic logic [1:0] ref_sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Per-cycle scoreboard: called #1 after inputs are driven.
    task automatic observe();
        ent_t  e;
        logic  p;
        logic [1:0] nv;
        check("predict_v", 32'(predict_v_o), 32'(pred_due));
        if (predict_v_o) begin
            if (pred_q.size() == 0) check("pred_unexpected", 32'(1), 32'(0));
            else begin
                p = pred_q.pop_front();
                check("predict", 32'(predict_o), 32'(p));
            end
        end
        if (pending_wr) check("rmw_wr_follows", 32'(mem_v_o & mem_w_o), 32'(1));
        if (init_done_o && mem_v_o && mem_w_o) begin
            if (upd_q.size() == 0) check("wr_unexpected", 32'(1), 32'(0));
            else begin
                e  = upd_q.pop_front();
                nv = ref_sat(ref_ctr[e.idx], e.taken);
                check("rmw_rd_data", 32'(mem_data_i), 32'(ref_ctr[e.idx]));
                check("wr_addr", 32'(mem_addr_o), 32'(e.idx));
                check("wr_data", 32'(mem_data_o), 32'(nv));
                ref_ctr[e.idx] = nv;
            end
        end
        pending_wr = init_done_o && mem_v_o && !mem_w_o && !(read_v && read_ready_o);
        if (pending_wr) begin
            if (upd_q.size() == 0) check("upd_rd_unexpected", 32'(1), 32'(0));
            else check("upd_rd_addr", 32'(mem_addr_o), 32'(upd_q[0].idx));
        end
        pred_due = read_v && read_ready_o;
        if (pred_due) begin
            check("rd_issue", 32'({mem_v_o, mem_w_o, mem_addr_o}), 32'({1'b1, 1'b0, read_idx}));
            pred_q.push_back(ref_ctr[read_idx][1]);
        end
        last_enq = upd_v && upd_ready_o;
        if (last_enq) upd_q.push_back('{idx: upd_idx, taken: upd_taken});
        last_rr        = read_ready_o;
        last_mem_v     = mem_v_o;
        last_mem_w     = mem_w_o;
        last_addr      = mem_addr_o;
        last_upd_ready = upd_ready_o;
        last_pred      = predict_o;
    endtask

    task automatic step();
        #1;
        observe();
        @(negedge clk);
    endtask

    // Checks the full init sweep starting in the cycle reset is released.
    task automatic init_sweep();
        read_v = 1'b1; read_idx = 4'd1; upd_v = 1'b1; upd_idx = 4'd2; upd_taken = 1'b1;
        for (int i = 0; i < N; i++) begin
            #1;
            check("init_wr", 32'({mem_v_o, mem_w_o, mem_addr_o, mem_data_o}), 32'({1'b1, 1'b1, 4'(i), 2'b01}));
            check("init_busy", 32'({init_done_o, upd_ready_o, read_ready_o, predict_v_o}), 32'(0));
            @(negedge clk);
        end
        read_v = 1'b0; upd_v = 1'b0;
        #1;
        check("init_done", 32'(init_done_o), 32'(1));
        check("init_idle", 32'(mem_v_o), 32'(0));
        for (int i = 0; i < N; i++) begin
            check("init_sram", 32'(sram[i]), 32'(2'b01));
            ref_ctr[i] = 2'b01;
        end
        pred_due = 1'b0; pending_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_upd(input logic [IW-1:0] idx, input logic t);
        logic done;
        done = 1'b0;
        upd_v = 1'b1; upd_idx = idx; upd_taken = t;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            done = last_enq;
        end
        if (!done) check("push_timeout", 32'(0), 32'(1));
        upd_v = 1'b0;
    endtask

    task automatic drain();
        read_v = 1'b0; upd_v = 1'b0;
        for (int i = 0; i < 40 && (upd_q.size() != 0 || pending_wr); i++) step();
        check("drain_empty", 32'(upd_q.size()), 32'(0));
        step();
    endtask

    initial begin
        int   grants;
        logic forced;
        reset_n = 1'b0; read_v = 1'b0; read_idx = '0; upd_v = 1'b0; upd_idx = '0; upd_taken = 1'b0;
        pred_due = 1'b0; pending_wr = 1'b0;
        @(negedge clk);
        read_v = 1'b1; upd_v = 1'b1;
        #1;
        check("rst_outputs", 32'({mem_v_o, read_ready_o, upd_ready_o, init_done_o, predict_v_o, predict_o}), 32'(0));
        @(negedge clk);

        // Init sweep.
        reset_n = 1'b1;
        init_sweep();

        // Saturation: four taken updates on idx 3, then read it back.
        for (int k = 0; k < 4; k++) push_upd(4'd3, 1'b1);
        drain();
        check("sat_sram", 32'(sram[3]), 32'(2'b11));
        read_v = 1'b1; read_idx = 4'd3;
        step();
        check("sat_read_rr", 32'(last_rr), 32'(1));
        read_v = 1'b0;
        step();
        check("sat_pred", 32'(last_pred), 32'(1));

        // Duplicate index ordering: taken then not-taken from 01.
        push_upd(4'd5, 1'b1);
        push_upd(4'd5, 1'b0);
        drain();
        check("dup_sram", 32'(sram[5]), 32'(2'b01));

        // Starvation: continuous reads with one pending update.
        read_v = 1'b1; read_idx = 4'd2; upd_v = 1'b1; upd_idx = 4'd7; upd_taken = 1'b1;
        step();
        check("starve_enq", 32'(last_enq), 32'(1));
        upd_v = 1'b0;
        grants = 0; forced = 1'b0;
        for (int i = 0; i < 20 && !forced; i++) begin
            step();
            if (last_rr) grants++;
            else forced = 1'b1;
        end
        check("starve_grants", 32'(grants), 32'(8));
        check("starve_upd_rd", 32'({forced, last_mem_v, last_mem_w, last_addr}), 32'({1'b1, 1'b1, 1'b0, 4'd7}));
        step();
        check("starve_upd_wr", 32'({last_rr, last_mem_w}), 32'({1'b0, 1'b1}));
        step();
        check("starve_resume", 32'(last_rr), 32'(1));
        drain();

        // Queue full while reads saturate the port.
        read_v = 1'b1; read_idx = 4'd4; upd_v = 1'b1;
        for (int k = 0; k < 4; k++) begin
            upd_idx = 4'(8 + k); upd_taken = k[0];
            step();
            check("full_enq", 32'(last_enq), 32'(1));
        end
        upd_idx = 4'd12; upd_taken = 1'b1;
        step();
        check("full_force", 32'({last_upd_ready, last_enq, last_rr, last_mem_v, last_mem_w}), 32'({1'b0, 1'b0, 1'b0, 1'b1, 1'b0}));
        step();
        check("full_upd_wr", 32'({last_upd_ready, last_rr, last_mem_w}), 32'({1'b0, 1'b0, 1'b1}));
        step();
        check("full_ready_back", 32'(last_upd_ready), 32'(1));
        drain();

        // Reset during UPD_WR with three entries queued.
        read_v = 1'b1; read_idx = 4'd6; upd_v = 1'b1;
        for (int k = 0; k < 3; k++) begin
            upd_idx = 4'(13 + k); upd_taken = 1'b1;
            step();
        end
        upd_v = 1'b0;
        forced = 1'b0;
        for (int i = 0; i < 20 && !forced; i++) begin
            step();
            forced = !last_rr;
        end
        check("rmw_rst_forced", 32'(forced), 32'(1));
        read_v = 1'b0;
        #1;
        check("rmw_rst_in_wr", 32'({mem_v_o, mem_w_o}), 32'({1'b1, 1'b1}));
        reset_n = 1'b0;
        #1;
        check("rmw_rst_clear", 32'({mem_v_o, mem_w_o, read_ready_o, upd_ready_o, init_done_o, predict_v_o, predict_o}), 32'(0));
        upd_q.delete(); pred_q.delete(); pending_wr = 1'b0; pred_due = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        init_sweep();
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_stale", 32'(last_mem_v), 32'(0));
        end
        read_v = 1'b1; read_idx = 4'd13;
        step();
        read_v = 1'b0;
        step();
        check("post_rst_pred", 32'(last_pred), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
